// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Occupancy encodings and the default bubble instruction.
// No logic; imported by each stage register.
package pipe_pkg;

  // Number of entries held by a skid stage register
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // RISC-V canonical NOP (addi x0, x0, 0), used to build the flush payload
  localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with a 2-entry skid buffer, flush and stall counter.
// Latency: 1 cycle from an accepted word to o_valid when the stage is empty.
// Backpressure: o_ready is registered (!skid_valid); up to two words are absorbed when i_ready drops.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 NB_DATA    = 96,
  parameter logic [NB_DATA-1:0] FLUSH_DATA = {NB_DATA{1'b0}},
  parameter int                 NB_CNT     = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  input  logic               i_flush,
  output logic [1:0]         o_occupancy,
  output logic [NB_CNT-1:0]  o_stall_cnt
);

  logic [NB_DATA-1:0] r_main_data;
  logic               r_main_valid;
  logic [NB_DATA-1:0] r_skid_data;
  logic               r_skid_valid;
  occ_e               r_occ;
  logic [NB_CNT-1:0]  r_stall_cnt;

  logic w_push;
  logic w_pop;
  logic w_stall;

  // ready depends only on the skid register, so no combinational path from i_valid/i_ready
  assign w_push  = i_valid & ~r_skid_valid;
  assign w_pop   = r_main_valid & i_ready;
  assign w_stall = r_main_valid & ~i_ready;

  assign o_ready     = ~r_skid_valid;
  assign o_data      = r_main_data;
  assign o_valid     = r_main_valid;
  assign o_occupancy = r_occ;
  assign o_stall_cnt = r_stall_cnt;

  // Occupancy state machine: main register feeds the output, skid absorbs one extra word on stall
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_main_data  <= FLUSH_DATA;
      r_main_valid <= 1'b0;
      r_skid_data  <= FLUSH_DATA;
      r_skid_valid <= 1'b0;
      r_occ        <= OCC_EMPTY;
    end else if (i_flush) begin
      // flush wins over any push or pop in the same cycle
      r_main_data  <= FLUSH_DATA;
      r_main_valid <= 1'b0;
      r_skid_data  <= FLUSH_DATA;
      r_skid_valid <= 1'b0;
      r_occ        <= OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_push) begin
            r_main_data  <= i_data;
            r_main_valid <= 1'b1;
            r_occ        <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_main_data <= i_data;
          end else if (w_push) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
            r_occ        <= OCC_FULL;
          end else if (w_pop) begin
            r_main_data  <= FLUSH_DATA;
            r_main_valid <= 1'b0;
            r_occ        <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // o_ready is low here, so only a pop can change state
          if (w_pop) begin
            r_main_data  <= r_skid_data;
            r_skid_data  <= FLUSH_DATA;
            r_skid_valid <= 1'b0;
            r_occ        <= OCC_ONE;
          end
        end
        default: begin
          r_main_data  <= FLUSH_DATA;
          r_main_valid <= 1'b0;
          r_skid_data  <= FLUSH_DATA;
          r_skid_valid <= 1'b0;
          r_occ        <= OCC_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles the downstream stage refused a valid word; flush leaves it alone
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {NB_CNT{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + NB_CNT'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (NB_CNT=3 to reach saturation quickly).
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// All expected values are hand-derived constants.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int               NB_DATA = 96;
  localparam int               NB_CNT  = 3;
  localparam logic [95:0]      FLUSH   = {64'h0, RV_NOP};

  logic               clk;
  logic               i_rst;
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic [NB_DATA-1:0] o_data;
  logic               o_valid;
  logic               i_ready;
  logic               i_flush;
  logic [1:0]         o_occupancy;
  logic [NB_CNT-1:0]  o_stall_cnt;

  int n_checks;
  int n_pass;

  pipe_skid_reg #(
    .NB_DATA   (NB_DATA),
    .FLUSH_DATA(FLUSH),
    .NB_CNT    (NB_CNT)
  ) u_dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .i_flush    (i_flush),
    .o_occupancy(o_occupancy),
    .o_stall_cnt(o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // full output snapshot against expected values
  task automatic chk_out(input string tag, input logic vld, input logic [95:0] dat,
                         input logic rdy, input logic [1:0] occ);
    chk({tag, ".valid"}, 96'(o_valid), 96'(vld));
    chk({tag, ".data"},  o_data, dat);
    chk({tag, ".ready"}, 96'(o_ready), 96'(rdy));
    chk({tag, ".occ"},   96'(o_occupancy), 96'(occ));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    i_rst    = 1'b1;
    i_data   = '0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_flush  = 1'b0;

    // ---------------- reset then idle
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    step();
    chk_out("rst", 1'b0, FLUSH, 1'b1, 2'd0);
    chk("rst.stall", 96'(o_stall_cnt), 96'd0);

    // ---------------- stream 1..8 at full throughput
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_data = 96'(k);
      step();
      chk($sformatf("stream%0d.data", k), o_data, 96'(k));
      chk($sformatf("stream%0d.valid", k), 96'(o_valid), 96'd1);
      chk($sformatf("stream%0d.ready", k), 96'(o_ready), 96'd1);
    end
    i_valid = 1'b0;
    step();
    chk_out("drain", 1'b0, FLUSH, 1'b1, 2'd0);
    chk("stream.stall", 96'(o_stall_cnt), 96'd0);

    // ---------------- skid: A, B, C with downstream stalled
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 96'hA;
    step();
    chk_out("skidA", 1'b1, 96'hA, 1'b1, 2'd1);
    i_data = 96'hB;
    step();
    chk_out("skidB", 1'b1, 96'hA, 1'b0, 2'd2);
    chk("skidB.stall", 96'(o_stall_cnt), 96'd1);
    i_data = 96'hC;
    step();
    chk_out("skidHold", 1'b1, 96'hA, 1'b0, 2'd2);
    chk("skidHold.stall", 96'(o_stall_cnt), 96'd2);
    i_ready = 1'b1;
    step();
    chk_out("popB", 1'b1, 96'hB, 1'b1, 2'd1);
    step();
    chk_out("popC", 1'b1, 96'hC, 1'b1, 2'd1);
    i_valid = 1'b0;
    step();
    chk_out("skidDrain", 1'b0, FLUSH, 1'b1, 2'd0);
    chk("skid.stall", 96'(o_stall_cnt), 96'd2);

    // ---------------- flush while FULL with a word offered
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 96'h11;
    step();
    i_data = 96'h12;
    step();
    chk_out("preFlush", 1'b1, 96'h11, 1'b0, 2'd2);
    chk("preFlush.stall", 96'(o_stall_cnt), 96'd3);
    i_flush = 1'b1;
    i_data  = 96'hD;
    step();
    chk_out("flush", 1'b0, FLUSH, 1'b1, 2'd0);
    chk("flush.stall", 96'(o_stall_cnt), 96'd4);
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    chk_out("postFlush", 1'b0, FLUSH, 1'b1, 2'd0);

    // ---------------- stall counter saturation
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 96'hE;
    step();
    i_valid = 1'b0;
    repeat (10) step();
    chk("sat.stall", 96'(o_stall_cnt), 96'd7);
    chk("sat.data", o_data, 96'hE);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("satFlush.stall", 96'(o_stall_cnt), 96'd7);
    chk("satFlush.valid", 96'(o_valid), 96'd0);
    #2;
    i_rst = 1'b1;
    #1;
    chk("satRst.stall", 96'(o_stall_cnt), 96'd0);
    step();
    i_rst = 1'b0;

    // ---------------- asynchronous reset while FULL
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 96'h21;
    step();
    i_data = 96'h22;
    step();
    chk_out("fullPreRst", 1'b1, 96'h21, 1'b0, 2'd2);
    i_valid = 1'b0;
    #3;
    i_rst = 1'b1;
    #1;
    chk_out("asyncRst", 1'b0, FLUSH, 1'b1, 2'd0);
    chk("asyncRst.stall", 96'(o_stall_cnt), 96'd0);
    #2;
    i_rst   = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_data  = 96'h33;
    step();
    chk_out("firstPush", 1'b1, 96'h33, 1'b1, 2'd1);
    i_valid = 1'b0;
    step();
    chk_out("end", 1'b0, FLUSH, 1'b1, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed IF/ID stage register: a generic inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
- Upstream can stream one word per cycle while o_ready stays a registered signal, so there is no combinational ready path across the stage.
- Adds flush with a configurable bubble (NOP) payload, an occupancy output and a saturating stall counter.
- Used between any two CPU core stages (IF/ID, ID/EX, ...) in place of the hand-written per-stage registers.

Parameters:
- NB_DATA, 96, payload width in bits (e.g. instr + pc + pc_next = 3x32).
- FLUSH_DATA, {NB_DATA{1'b0}}, payload presented on o_data whenever the stage holds no valid entry (e.g. RISC-V NOP 0x00000013 in the low bits).
- NB_CNT, 16, width of the stall counter.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_data  input  NB_DATA  upstream payload.
- i_valid  input  1  upstream payload valid.
- o_ready  output  1  stage can accept; registered, equals !skid_valid.
- o_data  output  NB_DATA  downstream payload; FLUSH_DATA when o_valid=0.
- o_valid  output  1  downstream payload valid.
- i_ready  input  1  downstream accepts.
- i_flush  input  1  synchronous flush; discards all held entries.
- o_occupancy  output  2  number of held entries: 0, 1 or 2.
- o_stall_cnt  output  NB_CNT  cycles with o_valid=1 and i_ready=0, saturating.

Behaviour:
- Storage:
  - main register (main_data, main_valid) drives o_data/o_valid.
  - skid register (skid_data, skid_valid).
- Definitions: push = i_valid & o_ready; pop = o_valid & i_ready.
- Reset, asynchronous, takes effect immediately:
  - main_valid=0, skid_valid=0.
  - main_data=FLUSH_DATA, skid_data=FLUSH_DATA.
  - o_ready=1, o_occupancy=0, o_stall_cnt=0.
- States and transitions:
  - EMPTY (occ 0): push -> ONE; main loads i_data.
  - ONE (occ 1):
    - push&pop -> ONE; main loads i_data.
    - push&!pop -> FULL; skid loads i_data.
    - !push&pop -> EMPTY; main_data<=FLUSH_DATA.
    - neither -> ONE.
  - FULL (occ 2): o_ready=0, so no push is possible.
    - pop -> ONE; main<=skid; skid_valid<=0.
    - !pop -> FULL.
- Latency and ordering:
  - Latency is 1 cycle from push to o_valid when the stage is EMPTY.
  - Strict FIFO order; no word is dropped or duplicated.
  - Full throughput of 1 word/cycle when i_ready is held at 1.
- Stall hold: while o_valid=1 and i_ready=0, o_data and o_valid are stable (AXI-style hold).
- Flush:
  - i_flush=1 has priority over push and pop in the same cycle.
  - Next cycle: both valids=0, both data=FLUSH_DATA, occupancy=0, o_ready=1.
  - A word presented with i_valid during the flush cycle is discarded; o_ready may read 1 that cycle, and upstream must treat the flush as its own kill.
  - Flush does not clear o_stall_cnt.
- Stall counter:
  - Increments by 1 each cycle with o_valid&!i_ready.
  - Holds at 2^NB_CNT-1 (no wrap).
  - Cleared only by reset.
- Reset mid-operation: all state returns to reset values asynchronously, and held entries are lost. The first push is accepted on the first rising edge after i_rst deasserts.
- No combinational path from i_ready or i_valid to o_ready. o_data and o_valid come directly from registers.

Decomposition:
- Shared package pipe_pkg: occupancy encodings OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2, plus the default NOP constant RV_NOP=32'h00000013 used to build FLUSH_DATA at instantiation.
- No sub-module. The stall counter is small enough to stay inline; at most a generic sat_counter may be factored out if another stage needs one.

Test Plan:
- Reset then idle -> o_valid=0, o_ready=1, o_data=FLUSH_DATA, o_occupancy=0, o_stall_cnt=0.
- Stream 0x1..0x8 with i_valid=1 and i_ready=1 -> o_data shows 0x1..0x8 on consecutive cycles one cycle after each push, o_ready stays 1 throughout.
- Push 0xA, 0xB, 0xC with i_ready=0 -> occupancy 1 then 2, o_ready=0 after 0xB, and 0xC is held upstream. Then raise i_ready -> output order 0xA, 0xB, 0xC; o_stall_cnt equals the number of i_ready=0 cycles with o_valid=1.
- FULL with i_flush=1 and i_valid=1 (0xD) in the same cycle -> next cycle o_valid=0, occupancy=0, o_data=FLUSH_DATA, o_ready=1; 0xD never appears on the output.
- With NB_CNT=3, hold i_ready=0 with o_valid=1 for 10 cycles -> o_stall_cnt saturates at 7; a flush leaves it at 7 and a reset returns it to 0.
- Assert i_rst asynchronously between edges while FULL -> o_valid and o_occupancy drop to 0 before the next clk edge; a push on the first edge after release appears on the output one cycle later.
